// File: rtl/io_hex_display.sv
// Sequential double-dabble binary-to-BCD converter that drives six seven-segment digits.
// Each load starts a 32-iteration conversion. A load that arrives mid-conversion is held in a one-deep pending slot.
module io_hex_display #(
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit DASH_ON_OVF   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [23:0] bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [5:0][6:0] RST_HEX = BLANK_LEADING ? {{5{7'h7F}}, 7'h40} : {6{7'h40}};

    state_t          state, state_nx;
    logic [31:0]     shreg;
    logic [23:0]     bcd_work, bcd_adj;
    logic            ovf_work;
    logic [4:0]      iter;
    logic            pend_vld;
    logic [31:0]     pend_val;
    logic            start;
    logic [31:0]     start_val;
    logic [5:0][6:0] hex_q, hex_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign busy = (state != IDLE);
    // A fresh load beats the queued value when both are present at the restart point.
    assign start     = ((state == IDLE) && load) || ((state == DONE) && (load || pend_vld));
    assign start_val = load ? value : pend_val;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (load) state_nx = CONV;
            CONV: if (iter == 5'd31) state_nx = DONE;
            DONE: state_nx = start ? CONV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_work;
        for (int k = 0; k < 6; k++)
            if (bcd_work[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
    end

    // Walk from the top digit down; a digit is lit once a nonzero digit has been seen at or above it.
    always_comb begin
        logic       lit;
        logic [3:0] nib;
        lit    = 1'b0;
        nib    = '0;
        hex_nx = '0;
        for (int k = 5; k >= 0; k--) begin
            nib = bcd_work[4*k +: 4];
            if (nib != 4'd0 || k == 0) lit = 1'b1;
            if (DASH_ON_OVF && ovf_work)   hex_nx[k] = 7'h3F;
            else if (BLANK_LEADING && !lit) hex_nx[k] = 7'h7F;
            else                            hex_nx[k] = seg7(nib);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd_work <= '0;
            ovf_work <= 1'b0;
            iter     <= '0;
            pend_vld <= 1'b0;
            pend_val <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
            hex_q    <= RST_HEX;
        end else begin
            state <= state_nx;
            done  <= (state == DONE);
            if (start) begin
                shreg    <= start_val;
                bcd_work <= '0;
                ovf_work <= (start_val > 32'd999_999);
                iter     <= '0;
                pend_vld <= 1'b0;
            end else if (state == CONV) begin
                // Bits shifted out of the top of bcd_work are lost; only the overflow case produces any.
                bcd_work <= {bcd_adj[22:0], shreg[31]};
                shreg    <= {shreg[30:0], 1'b0};
                iter     <= iter + 5'd1;
                if (load) begin
                    pend_vld <= 1'b1;
                    pend_val <= value;
                end
            end
            if (state == DONE) begin
                overflow <= ovf_work;
                bcd      <= bcd_work;
                hex_q    <= hex_nx;
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
endmodule

// File: tb/tb_io_hex_display.sv
// Bench for io_hex_display. The reference model works from decimal arithmetic on the loaded value.
// It covers reset, directed and random conversions, queued writes and reset in the middle of a conversion.
module tb_io_hex_display;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value = '0;
    logic        load  = 1'b0;
    logic        busy, done, overflow;
    logic [23:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hx [6];

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    io_hex_display dut (
        .clock(clock), .reset(reset), .value(value), .load(load),
        .busy(busy), .done(done), .overflow(overflow), .bcd(bcd),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clock = ~clock;

    assign hx[0] = hex0;
    assign hx[1] = hex1;
    assign hx[2] = hex2;
    assign hx[3] = hex3;
    assign hx[4] = hex4;
    assign hx[5] = hex5;

    // Low six decimal digits of v, packed as BCD.
    function automatic logic [23:0] m_bcd(input logic [31:0] v);
        int unsigned r;
        logic [23:0] b;
        r = v % 1000000;
        b = '0;
        for (int k = 0; k < 6; k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic [6:0] m_hex(input logic [31:0] v, input int k);
        int unsigned r;
        int digs [6];
        int msd;
        if (v > 999999) return 7'h3F;
        r = v;
        msd = 0;
        for (int i = 0; i < 6; i++) begin
            digs[i] = int'(r % 10);
            r = r / 10;
            if (digs[i] != 0) msd = i;
        end
        if (k > msd) return 7'h7F;
        return SEG[digs[k]];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic run_one(input string name, input logic [31:0] v);
        int n;
        value = v; load = 1'b1; step(); load = 1'b0;
        wait_done(40, n);
        n = n + 1;
        n_chk++;
        if (n !== 34) begin n_fail++; $display("FAIL %s latency: got %0d want 34", name, n); end
        n_chk++;
        if (bcd !== m_bcd(v)) begin n_fail++; $display("FAIL %s bcd: got %h want %h", name, bcd, m_bcd(v)); end
        n_chk++;
        if (overflow !== (v > 999999)) begin n_fail++; $display("FAIL %s overflow: got %b want %b", name, overflow, v > 999999); end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (hx[k] !== m_hex(v, k)) begin n_fail++; $display("FAIL %s hex%0d: got %h want %h", name, k, hx[k], m_hex(v, k)); end
        end
        step();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s post-done: done=%b busy=%b want 0 0", name, done, busy); end
    endtask

    task automatic check_reset_state(input string name);
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || bcd !== 24'h0) begin
            n_fail++;
            $display("FAIL %s flags: busy=%b done=%b ovf=%b bcd=%h want 0 0 0 000000", name, busy, done, overflow, bcd);
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (hx[k] !== (k == 0 ? 7'h40 : 7'h7F)) begin n_fail++; $display("FAIL %s hex%0d: got %h want %h", name, k, hx[k], k == 0 ? 7'h40 : 7'h7F); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_directed();
        run_one("d123456", 32'd123456);
        run_one("d42", 32'd42);
        run_one("d1000000", 32'd1000000);
        run_one("d0", 32'd0);
        run_one("d999999", 32'd999999);
        run_one("dmax", 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: v = $urandom;
                1: v = $urandom_range(0, 1999999);
                default: v = $urandom_range(0, 999);
            endcase
            run_one($sformatf("rnd%0d", i), v);
        end
    endtask

    // Loads at +5 and +10 land mid-conversion; only the later one survives.
    task automatic test_queue();
        int n;
        value = 32'd7; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        value = 32'd9; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        value = 32'd5; load = 1'b1; step(); load = 1'b0;
        wait_done(30, n);
        n_chk++;
        if (n + 11 !== 34 || bcd !== 24'h7) begin n_fail++; $display("FAIL queue first: t=%0d bcd=%h want 34 000007", n + 11, bcd); end
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL queue busy: got %b want 1", busy); end
        step();
        wait_done(40, n);
        n = n + 1;
        n_chk++;
        if (n !== 33 || bcd !== 24'h5) begin n_fail++; $display("FAIL queue second: gap=%0d bcd=%h want 33 000005", n, bcd); end
        n_chk++;
        if (hex0 !== 7'h12 || hex1 !== 7'h7F) begin n_fail++; $display("FAIL queue hex: hex0=%h hex1=%h want 12 7F", hex0, hex1); end
        step();
    endtask

    // A load exactly on the restart cycle overrides a queued value.
    task automatic test_back_to_back();
        int n;
        value = 32'd7; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        value = 32'd9; load = 1'b1; step(); load = 1'b0;
        repeat (27) step();
        value = 32'd3; load = 1'b1; step(); load = 1'b0;
        n_chk++;
        if (done !== 1'b1 || bcd !== 24'h7) begin n_fail++; $display("FAIL b2b first: done=%b bcd=%h want 1 000007", done, bcd); end
        step();
        wait_done(40, n);
        n = n + 1;
        n_chk++;
        if (n !== 33 || bcd !== 24'h3) begin n_fail++; $display("FAIL b2b second: gap=%0d bcd=%h want 33 000003", n, bcd); end
        step();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        value = 32'd999999; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        value = 32'd5; load = 1'b1; step(); load = 1'b0;
        repeat (4) step();
        reset = 1'b1; step(); reset = 1'b0;
        check_reset_state("rstmid");
        pulses = 0;
        repeat (45) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        n_chk++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rstmid activity: got %0d busy/done cycles want 0", pulses); end
        check_reset_state("rstmid_after");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_queue();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
